// File: rtl/rr_mux_arbiter_pkg.sv
// rr_mux_arbiter_pkg: shared state encoding and width helpers for the round-robin mux arbiter
package rr_mux_arbiter_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int t);
    return (t > 2) ? $clog2(t) : 1;
  endfunction
endpackage

// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if: requester bundle plus shared output channel; slave is the arbiter side
interface rr_mux_arbiter_if #(parameter int NUM_REQ = 4, parameter int DATA_W = 8);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data;
  logic [NUM_REQ-1:0]        gnt;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_ready;
  logic                      timeout;
  modport master (output req, data, out_ready, input gnt, out_valid, out_data, timeout);
  modport slave (input req, data, out_ready, output gnt, out_valid, out_data, timeout);
endinterface

// File: rtl/rr_mux_arbiter_pick.sv
// rr_priority_pick: first set request at or after ptr, wrapping modulo NUM_REQ
module rr_priority_pick import rr_mux_arbiter_pkg::*; #(
  parameter int NUM_REQ = 4,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               found,
  output logic [IW-1:0]      idx
);
  logic [IW-1:0] c;
  // scan from the farthest offset down so the closest set bit after ptr wins last
  always_comb begin
    idx = '0;
    c = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      c = IW'((int'(ptr) + i) % NUM_REQ);
      if (req[c]) idx = c;
    end
  end
  assign found = |req;
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter owning a registered-select N:1 mux; RR_MUX_ARBITER_TIMEOUT_EN adds stall timeout
module rr_mux_arbiter import rr_mux_arbiter_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic clk,
  input logic reset,
  rr_mux_arbiter_if.slave bus
);
  localparam int IW = idx_w(NUM_REQ);
  state_t state, state_n;
  logic [IW-1:0] g, g_n, ptr, ptr_n, g_inc, pick_ptr, win;
  logic found, xfer;
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
  localparam int CW = cnt_w(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt, cnt_n;
  logic to_q, to_n;
`endif
  assign g_inc = (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
  assign xfer = (state == GRANT) && bus.out_ready;
  assign pick_ptr = xfer ? g_inc : ptr;
  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(bus.req), .ptr(pick_ptr), .found(found), .idx(win)
  );
  // state, held select and priority pointer
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      g <= '0;
      ptr <= '0;
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
      cnt <= '0;
      to_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      g <= g_n;
      ptr <= ptr_n;
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
      cnt <= cnt_n;
      to_q <= to_n;
`endif
    end
  // arbitration, transfer rotation and withdrawal (withdrawal beats re-arbitration)
  always_comb begin
    state_n = state;
    g_n = g;
    ptr_n = ptr;
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
    cnt_n = cnt;
    to_n = 1'b0;
`endif
    if (state == IDLE) begin
      state_n = found ? GRANT : IDLE;
      g_n = found ? win : g;
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
      cnt_n = '0;
`endif
    end else if (xfer) begin
      ptr_n = g_inc;
      state_n = found ? GRANT : IDLE;
      g_n = found ? win : g;
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
      cnt_n = '0;
`endif
    end else if (!bus.req[g]) begin
      state_n = IDLE;
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
      state_n = IDLE;
      ptr_n = g_inc;
      to_n = 1'b1;
    end else begin
      cnt_n = cnt + 1'b1;
`endif
    end
  end
  // grant decode and output mux driven from the registered select
  always_comb begin
    bus.gnt = '0;
    if (state == GRANT) bus.gnt[g] = 1'b1;
    bus.out_valid = (state == GRANT);
    bus.out_data = bus.out_valid ? bus.data[g*DATA_W +: DATA_W] : '0;
  end
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
  assign bus.timeout = to_q;
`else
  assign bus.timeout = 1'b0;
`endif
endmodule
